vigna_bus_arbiter: RTL and testbench
====================================

VIGNA_BUS_ARBITER -- requirements
Module: vigna_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning max cycles waiting for m_ready before forced completion (0 = never).
REQ-002 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports i_valid in 1, i_ready out 1, i_addr in 32, i_rdata out 32: core instruction port.
REQ-005 SHALL have ports d_valid in 1, d_ready out 1, d_addr in 32, d_wdata in 32, d_wstrb in 4, d_rdata out 32: core data port (d_wstrb 0 = read).
REQ-006 SHALL have ports m_valid out 1, m_ready in 1, m_addr out 32, m_wdata out 32, m_wstrb out 4, m_rdata in 32: single memory port.
REQ-007 SHALL have port bus_err  output  1  sticky timeout flag.

Function
REQ-010 Protocol on all ports: valid held until ready; ready is a one-cycle pulse; rdata valid in the ready cycle.
REQ-011 States: IDLE, I_REQ, D_REQ, I_RESP, D_RESP.
REQ-012 IDLE: exactly one of i_valid/d_valid -> grant it; both -> grant port not in last_grant; neither -> stay.
REQ-013 On grant: register m_addr = {addr[31:2],2'b00}, m_wdata, m_wstrb, offset = addr[1:0]; m_valid=1 next cycle; last_grant updated.
REQ-014 Instruction grant: m_wstrb=0, m_wdata=0, no lane shift.
REQ-015 Data grant: m_wstrb = (d_wstrb << offset) truncated to 4 bits; m_wdata = d_wdata << 8*offset; no split of misaligned accesses.
REQ-016 x_REQ: hold m_valid/m_addr/m_wdata/m_wstrb stable; on m_ready -> capture rdata, m_valid=0, go x_RESP.
REQ-017 I_RESP: i_ready=1 for one cycle, i_rdata = captured m_rdata; -> IDLE.
REQ-018 D_RESP: d_ready=1 for one cycle, d_rdata = captured m_rdata >> 8*offset (zero-filled); -> IDLE.
REQ-019 i_rdata/d_rdata SHALL be registered and hold until that port's next completion.
REQ-020 Latency: grant in IDLE cycle N -> m_valid at N+1; m_ready at cycle M -> port ready at M+1; IDLE at M+2.
REQ-021 IDLE SHALL not re-grant a port in the cycle its ready pulses (guaranteed by RESP state).
REQ-022 Timeout counter: cleared on entry to x_REQ, increments each x_REQ cycle without m_ready; reaching TIMEOUT_CYCLES (nonzero) -> m_valid=0, rdata captured as 0, bus_err=1, go x_RESP.
REQ-023 m_ready in the same cycle as timeout expiry: treated as normal completion, bus_err unchanged.
REQ-024 m_ready outside x_REQ SHALL be ignored.
REQ-025 Requests arriving during a transaction wait in IDLE arbitration; none dropped.

Reset
REQ-030 resetn low at clock edge: state=IDLE, m_valid=0, m_addr=0, m_wdata=0, m_wstrb=0, i_ready=0, d_ready=0, i_rdata=0, d_rdata=0, bus_err=0, counter=0, last_grant=data (instruction wins first conflict).
REQ-031 Reset mid-transaction SHALL abort it with no ready pulse; late m_ready after reset ignored.

Structure
REQ-040 State encodings, port-id constants and default TIMEOUT_CYCLES SHALL live in shared package vigna_bus_pkg.
REQ-041 Lane shifting (wstrb/wdata left, rdata right) SHALL be sub-module vigna_lane_align, combinational.
REQ-042 Target 150-300 lines RTL; no memories or latches.

Verification
REQ-050 i_valid, i_addr=0x100, m_ready 2 cycles after m_valid, m_rdata=0x00000013 -> m_addr=0x100, m_wstrb=0, i_ready one pulse, i_rdata=0x13.
REQ-051 d store d_addr=0x203, d_wdata=0xAB, d_wstrb=0001 -> m_addr=0x200, m_wstrb=1000, m_wdata=0xAB000000, d_ready one pulse.
REQ-052 d load d_addr=0x202, m_rdata=0x12345678 -> d_rdata=0x00001234.
REQ-053 i_valid and d_valid both high in IDLE, repeated 3 times -> grant order I, D, I; each port's ready pulses once per request.
REQ-054 TIMEOUT_CYCLES=4, m_ready never -> m_valid drops after 4 cycles, i_ready pulses, i_rdata=0, bus_err=1 until reset.
REQ-055 resetn low during D_REQ, then m_ready -> no d_ready, all outputs at reset values, next request served normally.

Source files
------------

// File: rtl/vigna_bus_pkg.sv
// ============================================================================
// Module      : vigna_bus_pkg
// Description : Shared definitions for the Vigna core bus arbiter.
//               Arbiter state encoding, requesting-port identifiers and the
//               default memory-response timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vigna_bus_pkg;

  // Arbiter state machine encoding
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_I_REQ  = 3'd1,
    S_D_REQ  = 3'd2,
    S_I_RESP = 3'd3,
    S_D_RESP = 3'd4
  } state_t;

  // Requesting-port identifiers, used for round-robin bookkeeping
  localparam logic c_port_instr = 1'b0;
  localparam logic c_port_data  = 1'b1;

  // Default number of cycles to wait for m_ready before forcing completion
  localparam int c_timeout_default = 255;

endpackage

`default_nettype wire

// File: rtl/vigna_lane_align.sv
// ============================================================================
// Module      : vigna_lane_align
// Description : Combinational byte-lane alignment for sub-word accesses.
//               Write strobes/data are moved up to the byte lane selected by
//               the address offset; read data is moved down to lane 0 with
//               zero fill.
// Ports       : i_wr_offset/i_wstrb/i_wdata -> o_wstrb/o_wdata (left shift)
//               i_rd_offset/i_rdata         -> o_rdata         (right shift)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vigna_lane_align
  import vigna_bus_pkg::*;
(
  input  logic [1:0]  i_wr_offset,
  input  logic [3:0]  i_wstrb,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_rd_offset,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  // Strobe bits shifted past lane 3 are discarded: misaligned accesses are
  // never split, so the bytes that would cross the word boundary are lost.
  assign o_wstrb = i_wstrb << i_wr_offset;
  assign o_wdata = i_wdata << {i_wr_offset, 3'b000};
  assign o_rdata = i_rdata >> {i_rd_offset, 3'b000};

endmodule

`default_nettype wire

// File: rtl/vigna_bus_arbiter.sv
// ============================================================================
// Module      : vigna_bus_arbiter
// Description : Arbitrates the core instruction and data ports onto a single
//               valid/ready memory port. Alternates grants on conflict, aligns
//               sub-word data accesses, and forces completion with a sticky
//               error flag if memory does not answer within TIMEOUT_CYCLES.
// Ports       : clk, resetn (sync, active-low)
//               i_valid/i_ready/i_addr/i_rdata             instruction port
//               d_valid/d_ready/d_addr/d_wdata/d_wstrb/d_rdata  data port
//               m_valid/m_ready/m_addr/m_wdata/m_wstrb/m_rdata  memory port
//               bus_err                                    sticky timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vigna_bus_arbiter
  import vigna_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = c_timeout_default
) (
  input  logic        clk,
  input  logic        resetn,
  // instruction port
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  // data port
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  // memory port
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic [31:0] m_rdata,
  // status
  output logic        bus_err
);

  localparam logic [31:0] c_timeout = 32'(TIMEOUT_CYCLES);

  state_t      r_state;
  logic        r_last;
  logic [1:0]  r_off;
  logic [31:0] r_cnt;
  logic        r_m_valid;
  logic [31:0] r_m_addr;
  logic [31:0] r_m_wdata;
  logic [3:0]  r_m_wstrb;
  logic        r_i_ready;
  logic        r_d_ready;
  logic [31:0] r_i_rdata;
  logic [31:0] r_d_rdata;
  logic        r_bus_err;

  logic        w_grant_i;
  logic        w_grant_d;
  logic        w_expire;
  logic        w_is_data;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata;

  vigna_lane_align u_align (
    .i_wr_offset (d_addr[1:0]),
    .i_wstrb     (d_wstrb),
    .i_wdata     (d_wdata),
    .i_rd_offset (r_off),
    .i_rdata     (m_rdata),
    .o_wstrb     (w_wstrb),
    .o_wdata     (w_wdata),
    .o_rdata     (w_rdata)
  );

  // On conflict the port that did not win last time is served.
  assign w_grant_i = i_valid & (~d_valid | (r_last == c_port_data));
  assign w_grant_d = d_valid & ~w_grant_i;

  // Expiry fires on the cycle whose miss would bring the count to the limit,
  // so m_valid is high for exactly TIMEOUT_CYCLES cycles.
  assign w_expire  = (c_timeout != 32'd0) && ((r_cnt + 32'd1) == c_timeout);
  assign w_is_data = (r_state == S_D_REQ);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_last    <= c_port_data;
      r_off     <= 2'b00;
      r_cnt     <= 32'd0;
      r_m_valid <= 1'b0;
      r_m_addr  <= 32'd0;
      r_m_wdata <= 32'd0;
      r_m_wstrb <= 4'd0;
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      r_i_rdata <= 32'd0;
      r_d_rdata <= 32'd0;
      r_bus_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_i) begin
            r_m_addr  <= {i_addr[31:2], 2'b00};
            r_m_wdata <= 32'd0;
            r_m_wstrb <= 4'd0;
            r_off     <= i_addr[1:0];
            r_m_valid <= 1'b1;
            r_cnt     <= 32'd0;
            r_last    <= c_port_instr;
            r_state   <= S_I_REQ;
          end else if (w_grant_d) begin
            r_m_addr  <= {d_addr[31:2], 2'b00};
            r_m_wdata <= w_wdata;
            r_m_wstrb <= w_wstrb;
            r_off     <= d_addr[1:0];
            r_m_valid <= 1'b1;
            r_cnt     <= 32'd0;
            r_last    <= c_port_data;
            r_state   <= S_D_REQ;
          end
        end

        S_I_REQ, S_D_REQ: begin
          // A real response wins over a simultaneous expiry.
          if (m_ready) begin
            r_m_valid <= 1'b0;
            if (w_is_data) begin
              r_d_rdata <= w_rdata;
              r_d_ready <= 1'b1;
              r_state   <= S_D_RESP;
            end else begin
              r_i_rdata <= m_rdata;
              r_i_ready <= 1'b1;
              r_state   <= S_I_RESP;
            end
          end else if (w_expire) begin
            r_m_valid <= 1'b0;
            r_bus_err <= 1'b1;
            if (w_is_data) begin
              r_d_rdata <= 32'd0;
              r_d_ready <= 1'b1;
              r_state   <= S_D_RESP;
            end else begin
              r_i_rdata <= 32'd0;
              r_i_ready <= 1'b1;
              r_state   <= S_I_RESP;
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end

        S_I_RESP: begin
          r_i_ready <= 1'b0;
          r_state   <= S_IDLE;
        end

        S_D_RESP: begin
          r_d_ready <= 1'b0;
          r_state   <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign m_valid = r_m_valid;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign m_wstrb = r_m_wstrb;
  assign i_ready = r_i_ready;
  assign d_ready = r_d_ready;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;
  assign bus_err = r_bus_err;

endmodule

`default_nettype wire

// File: tb/tb_vigna_bus_arbiter.sv
// ============================================================================
// Module      : tb_vigna_bus_arbiter
// Description : Scoreboard bench for vigna_bus_arbiter. Stimulus pushes the
//               expected memory request and the expected port response into
//               queues; a memory responder and a response monitor pop and
//               compare independently.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vigna_bus_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_valid, i_ready;
  logic [31:0] i_addr, i_rdata;
  logic        d_valid, d_ready;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic        m_valid, m_ready;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic        bus_err;

  always #5 clk = ~clk;

  vigna_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .d_valid (d_valid),
    .d_ready (d_ready),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_wstrb (d_wstrb),
    .d_rdata (d_rdata),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_wstrb (m_wstrb),
    .m_rdata (m_rdata),
    .bus_err (bus_err)
  );

  // kind: 0 = normal, 1 = expect timeout (check hold length), 2 = aborted by reset
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    int          delay;
    int          kind;
  } mem_t;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
  } resp_t;

  mem_t  mem_q[$];
  resp_t resp_q[$];
  int    tests = 0;
  int    fails = 0;
  bit    late_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory responder: checks the presented request every cycle it is valid
  // and answers after the scripted number of cycles.
  initial begin
    bit seen;
    int waitc;
    int hold;
    seen  = 1'b0;
    waitc = 0;
    hold  = 0;
    m_ready = 1'b0;
    m_rdata = 32'd0;
    forever begin
      @(negedge clk);
      m_ready = 1'b0;
      if (late_ready) begin
        m_ready    = 1'b1;
        m_rdata    = 32'hDEAD_BEEF;
        late_ready = 1'b0;
      end else if (mem_q.size() > 0) begin
        if (m_valid) begin
          if (!seen) begin
            seen  = 1'b1;
            waitc = 0;
            hold  = 0;
          end
          hold++;
          chk("m_addr", m_addr, mem_q[0].addr);
          chk("m_wdata", m_wdata, mem_q[0].wdata);
          chk("m_wstrb", 32'(m_wstrb), 32'(mem_q[0].wstrb));
          if (mem_q[0].delay >= 0 && waitc == mem_q[0].delay) begin
            m_ready = 1'b1;
            m_rdata = mem_q[0].rdata;
            void'(mem_q.pop_front());
            seen = 1'b0;
          end else begin
            waitc++;
          end
        end else if (seen) begin
          if (mem_q[0].kind == 1) begin
            chk("timeout_hold", 32'(hold), 32'(TMO));
          end else if (mem_q[0].kind == 0) begin
            tests++;
            fails++;
            $display("FAIL m_valid_early_drop: dropped after %0d cycles, required held until m_ready", hold);
          end
          void'(mem_q.pop_front());
          seen = 1'b0;
        end
      end else if (m_valid) begin
        tests++;
        fails++;
        $display("FAIL unexpected_m_valid: m_valid=1 addr=0x%08h, required no request", m_addr);
      end
    end
  end

  // Response monitor: every ready pulse must match the oldest expectation.
  initial begin
    resp_t r;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      if (i_ready || d_ready) begin
        tests++;
        act = d_ready ? d_rdata : i_rdata;
        if (i_ready && d_ready) begin
          fails++;
          $display("FAIL both_ready: i_ready=1 d_ready=1, required one at a time");
        end else if (resp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_ready: i_ready=%0b d_ready=%0b, required no pulse", i_ready, d_ready);
        end else begin
          r = resp_q.pop_front();
          if ((d_ready != r.is_d) || (act !== r.rdata)) begin
            fails++;
            $display("FAIL resp: got port=%0s rdata=0x%08h, required port=%0s rdata=0x%08h",
                     d_ready ? "D" : "I", act, r.is_d ? "D" : "I", r.rdata);
          end
        end
      end
    end
  end

  task automatic do_req(input bit is_d, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic [31:0] maddr,
                        input logic [31:0] mwdata, input logic [3:0] mwstrb,
                        input logic [31:0] ret, input int delay, input int kind,
                        input logic [31:0] exp);
    bit done;
    mem_q.push_back('{maddr, mwdata, mwstrb, ret, delay, kind});
    resp_q.push_back('{is_d, exp});
    if (is_d) begin
      d_addr  = addr;
      d_wdata = wdata;
      d_wstrb = wstrb;
      d_valid = 1'b1;
    end else begin
      i_addr  = addr;
      i_valid = 1'b1;
    end
    done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (is_d ? d_ready : i_ready) begin
        done = 1'b1;
        break;
      end
    end
    i_valid = 1'b0;
    d_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL req_wait: no ready within 60 cycles for addr 0x%08h, required a pulse", addr);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  ic;
    int  dc;
    bit  ok;
    resetn  = 1'b0;
    i_valid = 1'b0;
    i_addr  = 32'd0;
    d_valid = 1'b0;
    d_addr  = 32'd0;
    d_wdata = 32'd0;
    d_wstrb = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_m_wstrb", 32'(m_wstrb), 32'd0);
    chk("rst_i_ready", 32'(i_ready), 32'd0);
    chk("rst_d_ready", 32'(d_ready), 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Conflict: both ports pending; expected grant order I, D, I.
    mem_q.push_back('{32'h300, 32'h0, 4'h0, 32'h1111_1111, 1, 0});
    mem_q.push_back('{32'h400, 32'h0, 4'h0, 32'h2222_2222, 0, 0});
    mem_q.push_back('{32'h304, 32'h0, 4'h0, 32'h3333_3333, 2, 0});
    resp_q.push_back('{1'b0, 32'h1111_1111});
    resp_q.push_back('{1'b1, 32'h2222_2222});
    resp_q.push_back('{1'b0, 32'h3333_3333});
    i_addr  = 32'h300;
    d_addr  = 32'h400;
    i_valid = 1'b1;
    d_valid = 1'b1;
    ic = 0;
    dc = 0;
    for (int c = 0; c < 100 && !(ic == 2 && dc == 1); c++) begin
      @(posedge clk);
      #1;
      if (i_ready) begin
        ic++;
        if (ic == 1) i_addr = 32'h304;
        else i_valid = 1'b0;
      end
      if (d_ready) begin
        dc++;
        d_valid = 1'b0;
      end
    end
    i_valid = 1'b0;
    d_valid = 1'b0;
    chk("arb_i_count", 32'(ic), 32'd2);
    chk("arb_d_count", 32'(dc), 32'd1);
    @(posedge clk);
    #1;

    // Aligned instruction fetch, memory answers 2 cycles after m_valid.
    do_req(1'b0, 32'h100, 32'h0, 4'h0, 32'h100, 32'h0, 4'h0, 32'h13, 2, 0, 32'h13);
    // Byte store to lane 3.
    do_req(1'b1, 32'h203, 32'hAB, 4'b0001, 32'h200, 32'hAB00_0000, 4'b1000,
           32'hCAFE_BABE, 1, 0, 32'h0000_00CA);
    // Halfword load from offset 2.
    do_req(1'b1, 32'h202, 32'h0, 4'h0, 32'h200, 32'h0, 4'h0, 32'h1234_5678, 0, 0, 32'h0000_1234);
    // Misaligned fetch: address aligned down, no lane shift on read data.
    do_req(1'b0, 32'h102, 32'h0, 4'h0, 32'h100, 32'h0, 4'h0, 32'h8765_4321, 0, 0, 32'h8765_4321);
    // Word store at offset 3: strobes truncated, upper bytes lost.
    do_req(1'b1, 32'h507, 32'h1122_3344, 4'b1111, 32'h504, 32'h4400_0000, 4'b1000,
           32'h0, 0, 0, 32'h0);
    // Halfword store at offset 2.
    do_req(1'b1, 32'h106, 32'h0000_BEEF, 4'b0011, 32'h104, 32'hBEEF_0000, 4'b1100,
           32'h5A5A_1234, 0, 0, 32'h0000_5A5A);
    chk("i_rdata_hold", i_rdata, 32'h8765_4321);
    chk("bus_err_clear", 32'(bus_err), 32'd0);

    // m_ready arrives in the very cycle the timeout would expire.
    do_req(1'b0, 32'h620, 32'h0, 4'h0, 32'h620, 32'h0, 4'h0, 32'h77, TMO - 1, 0, 32'h77);
    chk("bus_err_ready_at_expiry", 32'(bus_err), 32'd0);

    // Memory never answers: forced completion with zero data.
    do_req(1'b0, 32'h600, 32'h0, 4'h0, 32'h600, 32'h0, 4'h0, 32'hFFFF_FFFF, -1, 1, 32'h0);
    chk("bus_err_set", 32'(bus_err), 32'd1);
    do_req(1'b1, 32'h010, 32'h0, 4'h0, 32'h010, 32'h0, 4'h0, 32'h0BAD_F00D, 0, 0, 32'h0BAD_F00D);
    chk("bus_err_sticky", 32'(bus_err), 32'd1);

    // Reset in the middle of a data transaction, then a late m_ready.
    mem_q.push_back('{32'h700, 32'h0, 4'h0, 32'h0, -1, 2});
    d_addr  = 32'h700;
    d_wdata = 32'h0;
    d_wstrb = 4'h0;
    d_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("abort_m_valid_seen", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    resetn  = 1'b0;
    d_valid = 1'b0;
    @(posedge clk);
    #1;
    resetn     = 1'b1;
    late_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_m_valid", 32'(m_valid), 32'd0);
    chk("abort_m_addr", m_addr, 32'd0);
    chk("abort_m_wstrb", 32'(m_wstrb), 32'd0);
    chk("abort_d_ready", 32'(d_ready), 32'd0);
    chk("abort_d_rdata", d_rdata, 32'd0);
    chk("abort_i_rdata", i_rdata, 32'd0);
    chk("abort_bus_err", 32'(bus_err), 32'd0);
    do_req(1'b1, 32'h800, 32'h0, 4'h0, 32'h800, 32'h0, 4'h0, 32'h5555_AAAA, 1, 0, 32'h5555_AAAA);

    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (mem_q.size() == 0 && resp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d mem and %0d resp expectations left, required 0",
               mem_q.size(), resp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
